mem_stage: RTL
==============

# mem_stage

MEM stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM pipeline register. It performs the data-memory access for loads and stores over a req/ready bus. While an access is outstanding it stalls the upstream pipeline. It also contains the MEM/WB pipeline register that feeds write-back. Bus timeouts, misaligned addresses and illegal read+write combinations are converted into a bubble plus a sticky fault report.

## Interface
- MAX_WAIT, 16: maximum bus wait cycles before timeout; legal range ≥1; wait counter width is clog2(MAX_WAIT)+1.
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ALUResult_in  in  32  from EX/MEM: ALU result / effective address.
- DMemin_in  in  32  from EX/MEM: store data.
- RegWtaddr_in  in  5  from EX/MEM: destination register.
- DMemRead_in, DMemWrite_in, DMemtoReg_in, RegWrite_in  in  1 each  from EX/MEM: control bits.
- mem_req  out  1  bus request (combinational).
- mem_we  out  1  1 = write (equals DMemWrite_in while mem_req).
- mem_addr  out  32  equals ALUResult_in.
- mem_wdata  out  32  equals DMemin_in.
- mem_rdata  in  32  read data, valid when mem_ready.
- mem_ready  in  1  access completes in this cycle.
- Stall  out  1  combinational; drives en low on PC, IF/ID, ID/EX and EX/MEM.
- FaultClr  in  1  synchronous clear of the sticky fault.
- ALUResult_out  out  32  MEM/WB: ALU result.
- MemData_out  out  32  MEM/WB: load data, 0 for non-loads.
- RegWtaddr_out  out  5  MEM/WB: destination register.
- DMemtoReg_out, RegWrite_out  out  1 each  MEM/WB control.
- Fault  out  1  sticky fault flag.
- FaultCause  out  2  01 misaligned, 10 read+write both set, 11 timeout.
- FaultAddr  out  32  ALUResult_in of the faulting instruction.

## Operation
- Access decode:
  - access = DMemRead_in | DMemWrite_in.
  - illegal = (DMemRead_in & DMemWrite_in) | (access & ALUResult_in[1:0] != 0).
  - legal = access & ~illegal.
- FSM states:
  - IDLE: if legal, mem_req=1 this cycle. With mem_ready, the access completes this cycle (zero-wait). Without mem_ready, go to BUSY and set cnt=1.
  - BUSY: mem_req=1; upstream is frozen, so inputs are stable. With mem_ready, complete and go to IDLE. If cnt==MAX_WAIT and ~mem_ready, timeout: go to IDLE. Otherwise cnt+1.
- mem_req = legal & ~rst. It is never asserted for illegal or non-memory instructions.
- Stall = legal & ~mem_ready & ~timeout_now, where timeout_now = BUSY & cnt==MAX_WAIT & ~mem_ready.
- MEM/WB register update each rising edge:
  - Stall=1: bubble. RegWrite_out<=0, DMemtoReg_out<=0; other fields hold.
  - Stall=0, no fault this cycle: capture all fields. MemData_out<=mem_rdata if DMemRead_in, else 0.
  - Stall=0, fault this cycle (illegal, or timeout_now): bubble as above. No bus write occurs for illegal instructions.
- Fault register:
  - On a fault event with Fault=0: Fault<=1 and load FaultCause/FaultAddr.
  - On a fault event with Fault=1: Fault, FaultCause and FaultAddr hold (first fault wins).
  - FaultClr=1 clears Fault only. If FaultClr and a new fault event occur in the same cycle, the new fault is recorded.
- A ready that arrives in the timeout cycle counts as completion, not timeout.
- mem_ready while mem_req=0 is ignored.

## Timing
- Reset (async): state IDLE, cnt 0, all MEM/WB outputs 0, Fault/FaultCause/FaultAddr 0. mem_req is forced to 0 immediately.
- Zero-wait access: one cycle in MEM, Stall never asserted, MEM/WB valid after the next edge.
- N-wait access (ready in the Nth cycle after request, N≤MAX_WAIT): Stall is high for N cycles; the result is captured at the edge ending the ready cycle.
- Timeout: Stall is high for exactly MAX_WAIT cycles. Stall drops in the timeout cycle. Fault is visible after the following edge and RegWrite_out=0.
- Reset mid-BUSY aborts the access with no MEM/WB update and no fault.

## Test plan
- Zero-wait load: ALUResult_in=0x100, DMemRead=1, RegWrite=1, DMemtoReg=1, RegWtaddr=5, mem_ready=1 with rdata=0xDEADBEEF -> Stall never high; next cycle MemData_out=0xDEADBEEF, RegWtaddr_out=5, RegWrite_out=1.
- Store with 3 wait cycles: addr 0x200, data 0x12345678 -> mem_req/mem_we high with mem_wdata=0x12345678 for 4 cycles, Stall high for 3, RegWrite_out=0 throughout, MemData_out=0.
- Timeout with MAX_WAIT=4: load, mem_ready held 0 -> Stall high 4 cycles then low; Fault=1, FaultCause=11, FaultAddr=address; RegWrite_out=0.
- Misaligned load at 0x102 -> mem_req never asserts, Stall=0, Fault=1, FaultCause=01, FaultAddr=0x102, bubble in MEM/WB. A subsequent timeout leaves FaultCause=01; FaultClr then clears Fault.
- DMemRead=DMemWrite=1 at 0x40 -> no bus request, FaultCause=10.
- rst pulsed in the 2nd wait cycle -> mem_req and all outputs go to 0 immediately, state IDLE, Fault=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: data-memory access over a req/ready bus with upstream stall and MEM/WB register.
// Bus faults (misaligned, read+write, timeout) become a bubble plus a sticky first-fault report.
module mem_stage #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] DMemin_in,
    input  logic [4:0]  RegWtaddr_in,
    input  logic        DMemRead_in,
    input  logic        DMemWrite_in,
    input  logic        DMemtoReg_in,
    input  logic        RegWrite_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        Stall,
    input  logic        FaultClr,
    output logic [31:0] ALUResult_out,
    output logic [31:0] MemData_out,
    output logic [4:0]  RegWtaddr_out,
    output logic        DMemtoReg_out,
    output logic        RegWrite_out,
    output logic        Fault,
    output logic [1:0]  FaultCause,
    output logic [31:0] FaultAddr
);
    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          access, misaligned, rdwr, illegal, legal;
    logic          timeout_now, fault_ev;
    logic [1:0]    cause;

    assign access      = DMemRead_in | DMemWrite_in;
    assign rdwr        = DMemRead_in & DMemWrite_in;
    assign misaligned  = access & (ALUResult_in[1:0] != 2'b00);
    assign illegal     = rdwr | misaligned;
    assign legal       = access & ~illegal;
    // A ready arriving in the last allowed wait cycle wins over the timeout.
    assign timeout_now = (state == BUSY) & (cnt == CNT_MAX) & ~mem_ready;
    assign fault_ev    = illegal | timeout_now;
    assign cause       = rdwr ? 2'b10 : (misaligned ? 2'b01 : 2'b11);

    assign mem_req   = legal & ~rst;
    assign mem_we    = DMemWrite_in & mem_req;
    assign mem_addr  = ALUResult_in;
    assign mem_wdata = DMemin_in;
    assign Stall     = legal & ~mem_ready & ~timeout_now & ~rst;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (legal && !mem_ready) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CW'(1);
                end
            end
            BUSY: begin
                if (mem_ready || timeout_now || !legal) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Stalled or faulting cycles insert a bubble; data fields keep their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUResult_out <= '0;
            MemData_out   <= '0;
            RegWtaddr_out <= '0;
            DMemtoReg_out <= 1'b0;
            RegWrite_out  <= 1'b0;
        end else if (Stall || fault_ev) begin
            DMemtoReg_out <= 1'b0;
            RegWrite_out  <= 1'b0;
        end else begin
            ALUResult_out <= ALUResult_in;
            MemData_out   <= DMemRead_in ? mem_rdata : 32'h0;
            RegWtaddr_out <= RegWtaddr_in;
            DMemtoReg_out <= DMemtoReg_in;
            RegWrite_out  <= RegWrite_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Fault      <= 1'b0;
            FaultCause <= 2'b00;
            FaultAddr  <= '0;
        end else if (fault_ev && (!Fault || FaultClr)) begin
            Fault      <= 1'b1;
            FaultCause <= cause;
            FaultAddr  <= ALUResult_in;
        end else if (FaultClr) begin
            Fault <= 1'b0;
        end
    end
endmodule
